mem_access_stage: RTL

//  Memory (MEM) stage between the E/M pipeline register and writeback. Drives the

---
 rtl/mem_access_stage.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory request/ack, store alignment, load formatting, M/W register.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_out,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_index,
  input  logic [3:0]  dm_w_en,
  input  logic        wb_sel,
  input  logic        wb_en,
  input  logic [2:0]  func3,
  input  logic        ecall_sig,
  output logic        dmem_req,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_o,
  output logic [31:0] wb_data_reg,
  output logic [4:0]  rd_index_reg,
  output logic        wb_en_reg,
  output logic        ecall_sig_reg,
  output logic        bus_err,
  output logic        misalign_o
);

  localparam int CW =
    (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        r_state;
  logic [CW-1:0] r_wait_cnt;

  logic          w_mem_op;
  logic          w_misal;
  logic          w_abort;
  logic          w_bubble;
  logic [31:0]   w_sh;
  logic [31:0]   w_load;
  logic [31:0]   w_wb_data;

  assign w_mem_op = wb_sel | (|dm_w_en);

`ifdef MISALIGN_TRAP_EN
  assign w_misal = w_mem_op &
    (((func3[1:0] == 2'b01) & alu_out[0]) |
     ((func3[1:0] == 2'b10) & (|alu_out[1:0])));
`else
  assign w_misal = 1'b0;
`endif

  // Ack in the last allowed cycle wins over the timeout
  assign w_abort = w_mem_op & ~w_misal & ~dmem_ack &
                   (r_wait_cnt == LAST);

  assign dmem_req   = w_mem_op & ~w_misal & ~w_abort;
  assign dmem_we    = dm_w_en;
  assign dmem_addr  = {alu_out[31:2], 2'b00};
  assign dmem_wdata = rs2_data << {alu_out[1:0], 3'b000};
  assign stall_o    = dmem_req & ~dmem_ack;
  assign w_bubble   = stall_o | w_abort | w_misal;

  assign w_sh = dmem_rdata >> {alu_out[1:0], 3'b000};

  always_comb begin
    w_load = {24'h0, w_sh[7:0]};
    case (func3)
      3'b000:  w_load = {{24{w_sh[7]}}, w_sh[7:0]};
      3'b001:  w_load = {{16{w_sh[15]}}, w_sh[15:0]};
      3'b010:  w_load = w_sh;
      3'b100:  w_load = {24'h0, w_sh[7:0]};
      3'b101:  w_load = {16'h0, w_sh[15:0]};
      default: w_load = {24'h0, w_sh[7:0]};
    endcase
  end

  assign w_wb_data = wb_sel ? w_load : alu_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_wait_cnt    <= '0;
      wb_data_reg   <= '0;
      rd_index_reg  <= '0;
      wb_en_reg     <= 1'b0;
      ecall_sig_reg <= 1'b0;
      bus_err       <= 1'b0;
      misalign_o    <= 1'b0;
    end else begin
      bus_err    <= w_abort;
      misalign_o <= w_misal;
      case (r_state)
        IDLE:    r_state <= stall_o ? WAIT : IDLE;
        WAIT:    r_state <= stall_o ? WAIT : IDLE;
        default: r_state <= IDLE;
      endcase
      if (stall_o)
        r_wait_cnt <= (r_wait_cnt == CMAX) ? r_wait_cnt
                                           : r_wait_cnt + 1'b1;
      else
        r_wait_cnt <= '0;
      if (w_bubble) begin
        wb_en_reg     <= 1'b0;
        ecall_sig_reg <= 1'b0;
      end else begin
        wb_data_reg   <= w_wb_data;
        rd_index_reg  <= rd_index;
        wb_en_reg     <= wb_en;
        ecall_sig_reg <= ecall_sig;
      end
    end
  end

endmodule
